// File: rtl/router_modport_if.sv
`default_nettype none
// ============================================================================
// Module   : router_modport_if
// Purpose  : Bundles the source-side (pkt_valid, data_in, busy, error) and
//            destination-side (read_enb, vld_out, data_out) signals of the
//            packet router into one interface.
// Modports : slave  - router view (consumes packets, drives status/data out)
//            master - agent view (drives packets and read requests)
// Revision : 1.0 - initial release
// ============================================================================
interface router_modport_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       vld_out;
    logic       busy;
    logic       error;

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output data_out, vld_out, busy, error
    );

    modport master (
        output pkt_valid, data_in, read_enb,
        input  data_out, vld_out, busy, error
    );
endinterface
`default_nettype wire

// File: rtl/router_modport.sv
`default_nettype none
// ============================================================================
// Module   : router_modport
// Purpose  : Single-port packet router. Accepts byte-serial packets
//            (header, payload, parity), checks length and XOR parity, buffers
//            header and payload in a DEPTH x 8 FIFO and delivers them under a
//            read_enb handshake.
// Ports    : clk      - system clock (rising edge)
//            reset_n  - asynchronous active-low reset
//            bus      - router_modport_if.slave (pkt_valid, data_in, read_enb,
//                       data_out, vld_out, busy, error)
// Options  : ROUTER_SOFT_RESET_EN - flush the FIFO after TIMEOUT cycles of
//            vld_out high with no read_enb.
// Revision : 1.0 - initial release
// ============================================================================
module router_modport #(
    parameter int DEPTH   = 16
`ifdef ROUTER_SOFT_RESET_EN
   ,parameter int TIMEOUT = 30
`endif
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    router_modport_if.slave  bus
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    localparam logic [1:0] S_DECODE = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_data_out;

    logic [7:0]      r_acc;
    logic [7:0]      r_parity;
    logic [5:0]      r_len;
    logic [6:0]      r_cnt;
    logic            r_error;

    logic            w_full;
    logic            w_busy;
    logic            w_vld;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_hdr_en;
    logic            w_par_en;
    logic            w_flush;
    logic [c_AW-1:0] w_wr_addr;

    assign w_full  = (r_count == c_FULL);
    assign w_busy  = w_full | (r_state == S_CHECK);
    assign w_vld   = (r_count != '0);
    assign w_rd_en = bus.read_enb & w_vld;

    // ------------------------------------------------------------------
    // Packet FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_hdr_en     = 1'b0;
        w_par_en     = 1'b0;
        case (r_state)
            S_DECODE: begin
                if (bus.pkt_valid && !w_busy) begin
                    w_wr_en      = 1'b1;
                    w_hdr_en     = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_busy) begin
                    if (bus.pkt_valid) begin
                        w_wr_en = 1'b1;
                    end else begin
                        // pkt_valid low marks the parity byte; it is not buffered
                        w_par_en     = 1'b1;
                        w_next_state = S_CHECK;
                    end
                end
            end
            S_CHECK: w_next_state = S_DECODE;
            default: w_next_state = S_DECODE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_DECODE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Length / parity accumulation and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_parity <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_hdr_en) begin
                r_acc   <= bus.data_in;
                r_len   <= bus.data_in[7:2];
                r_cnt   <= '0;
                r_error <= 1'b0;
            end else if (w_wr_en) begin
                r_acc <= r_acc ^ bus.data_in;
                // Saturate so an overlong packet can never wrap back to a match
                if (r_cnt != 7'h7F) begin
                    r_cnt <= r_cnt + 7'd1;
                end
            end
            if (w_par_en) begin
                r_parity <= bus.data_in;
            end
            if (r_state == S_CHECK) begin
                r_error <= (r_acc != r_parity) | (r_cnt != {1'b0, r_len});
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional idle-timeout flush
    // ------------------------------------------------------------------
`ifdef ROUTER_SOFT_RESET_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0] r_idle;

    assign w_flush = (r_idle == c_TW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle <= '0;
        end else if (w_vld && !bus.read_enb && !w_flush) begin
            r_idle <= r_idle + 1'b1;
        end else begin
            r_idle <= '0;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO storage, pointers and occupancy
    // ------------------------------------------------------------------
    // A write landing on a flush edge goes to slot 0 of the emptied FIFO.
    assign w_wr_addr = w_flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_wr_en ? c_AW'(1) : '0;
            r_count  <= w_wr_en ? (c_AW+1)'(1) : '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (w_rd_en) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.vld_out  = w_vld;
    assign bus.busy     = w_busy;
    assign bus.error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_router_modport.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_modport
// Purpose  : Self-checking bench for router_modport. Table of packets with
//            expected error outcome, a byte scoreboard queue filled as bytes
//            are accepted and drained as the destination pops, plus directed
//            sequences for reset, full FIFO / wrap-around and idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_modport;

    typedef struct packed {
        logic [7:0]      hdr;
        logic [7:0][7:0] pay;     // pay[0] is the first payload byte
        logic [3:0]      n;
        logic            par_ok;  // 1: bench computes correct XOR parity
        logic [7:0]      par;     // used when par_ok = 0
        logic            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    router_modport_if bus ();

    router_modport #(.DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    logic       prev_err = 1'b0;
    logic [7:0] sb_q [$];
    vec_t       vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare data_out against the oldest accepted byte.
    task automatic compare_pop(input string name);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <scoreboard empty>", name, bus.data_out);
        end else begin
            exp = sb_q.pop_front();
            check(name, bus.data_out, exp);
        end
    endtask

    // Present one byte and wait (bounded) until the router consumes it.
    // Returns #1 after the consuming edge.
    task automatic send_byte(input logic valid, input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        bus.pkt_valid = valid;
        bus.data_in   = d;
        while (bus.busy === 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got busy=1 for %0d cycles expected busy=0", waited);
        end
        @(posedge clk);
        if (valid) sb_q.push_back(d);
        #1;
    endtask

    task automatic pop_check(input string name);
        @(negedge clk);
        check({name, "_vld"}, bus.vld_out, 1);
        bus.read_enb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.read_enb = 1'b0;
        compare_pop(name);
    endtask

    task automatic send_packet(input string tag, input vec_t v);
        logic [7:0] p;
        p = v.hdr;
        for (int i = 0; i < int'(v.n); i++) p ^= v.pay[i];
        if (!v.par_ok) p = v.par;
        check({tag, "_err_hold"}, bus.error, prev_err);
        send_byte(1'b1, v.hdr);
        check({tag, "_err_clr"}, bus.error, 0);
        for (int i = 0; i < int'(v.n); i++) send_byte(1'b1, v.pay[i]);
        send_byte(1'b0, p);
        bus.pkt_valid = 1'b0;
        check({tag, "_busy_check"}, bus.busy, 1);
        @(posedge clk);
        #1;
        check({tag, "_busy_one"}, bus.busy, 0);
        check({tag, "_error"}, bus.error, v.exp_err);
        check({tag, "_vld"}, bus.vld_out, 1);
        prev_err = v.exp_err;
    endtask

    // FIFO is full: hold d on the inputs, pop one entry, then let d in.
    task automatic held_send(input string tag, input logic valid, input logic [7:0] d);
        bus.pkt_valid = valid;
        bus.data_in   = d;
        check({tag, "_busy_full"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_busy_hold"}, bus.busy, 1);
        bus.read_enb = 1'b1;
        @(posedge clk);
        #1;
        bus.read_enb = 1'b0;
        compare_pop({tag, "_pop"});
        check({tag, "_busy_drop"}, bus.busy, 0);
        @(posedge clk);
        if (valid) sb_q.push_back(d);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last;
        vec_t       v;
        logic [7:0] p;

        // XOR of 0C,11,22,33 is 0C; vector 1 reuses it with a corrupt parity.
        vecs[0] = '{8'h0C, 64'h0000_0000_0033_2211, 4'd3, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{8'h0C, 64'h0000_0000_0033_2211, 4'd3, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 64'h0000_0000_0033_2211, 4'd3, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h04, 64'h0000_0000_0000_00A5, 4'd1, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'h1F, 64'h0007_0605_0403_0201, 4'd7, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'h08, 64'h0000_0000_00CC_BBAA, 4'd3, 1'b1, 8'h00, 1'b1};

        reset_n      = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        bus.read_enb  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 0);
        check("rst_vld_out",  bus.vld_out,  0);
        check("rst_busy",     bus.busy,     0);
        check("rst_error",    bus.error,    0);
        reset_n = 1'b1;

        // ---------------- table-driven packets ----------------
        for (int k = 0; k < 6; k++) begin
            send_packet($sformatf("vec%0d", k), vecs[k]);
            for (int j = 0; j <= int'(vecs[k].n); j++)
                pop_check($sformatf("vec%0d_data%0d", k, j));
            check($sformatf("vec%0d_empty", k), bus.vld_out, 0);
        end

        // read_enb on an empty FIFO is ignored
        last = bus.data_out;
        @(negedge clk);
        bus.read_enb = 1'b1;
        @(negedge clk);
        bus.read_enb = 1'b0;
        check("empty_read_data", bus.data_out, last);
        check("empty_read_vld",  bus.vld_out,  0);

        // ---------------- full FIFO and pointer wrap ----------------
        check("full_err_hold", bus.error, prev_err);
        send_byte(1'b1, 8'h50);                 // L = 20
        p = 8'h50;
        for (int i = 0; i < 15; i++) begin
            send_byte(1'b1, 8'h80 + 8'(i));
            p ^= 8'h80 + 8'(i);
        end
        check("full_vld", bus.vld_out, 1);
        for (int i = 15; i < 20; i++) begin
            held_send($sformatf("full_b%0d", i), 1'b1, 8'h80 + 8'(i));
            p ^= 8'h80 + 8'(i);
        end
        // parity byte presented while full must not be consumed until busy drops
        held_send("full_par", 1'b0, p);
        check("full_busy_check", bus.busy, 1);
        @(posedge clk);
        #1;
        check("full_busy_one", bus.busy, 0);
        check("full_error", bus.error, 0);
        prev_err = 1'b0;
        for (int j = 0; j < 15; j++) pop_check($sformatf("full_drain%0d", j));
        check("full_empty", bus.vld_out, 0);

        // ---------------- asynchronous reset ----------------
        v = '{8'h04, 64'h5A, 4'd1, 1'b0, 8'h00, 1'b1};
        send_packet("rstpkt", v);
        pop_check("rstpkt_pop");                 // data_out = 04, error = 1
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_data_out", bus.data_out, 0);
        check("arst_vld_out",  bus.vld_out,  0);
        check("arst_error",    bus.error,    0);
        sb_q.delete();
        prev_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        send_byte(1'b1, 8'h08);                  // partial packet
        send_byte(1'b1, 8'h77);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mid_vld",  bus.vld_out, 0);
        check("arst_mid_busy", bus.busy,    0);
        check("arst_mid_data", bus.data_out, 0);
        bus.pkt_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        send_packet("post_rst", vecs[0]);
        for (int j = 0; j < 4; j++) pop_check($sformatf("post_rst_data%0d", j));
        check("post_rst_empty", bus.vld_out, 0);

        // ---------------- idle timeout ----------------
        v = '{8'h04, 64'hC3, 4'd1, 1'b1, 8'h00, 1'b0};
        send_packet("idle", v);
        repeat (40) @(posedge clk);
        #1;
`ifdef ROUTER_SOFT_RESET_EN
        check("idle_flushed", bus.vld_out, 0);
        sb_q.delete();
`else
        check("idle_kept", bus.vld_out, 1);
        for (int j = 0; j < 2; j++) pop_check($sformatf("idle_data%0d", j));
        check("idle_empty", bus.vld_out, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
